conv_ram_master: RTL and testbench

- Master-side controller for the 64x8 single-port image RAM (clk, wr, 6-bit address, 8-bit din/dout, 1-cycle registered read, dout forced to 0 on write cycles).
- Loads an 8x8 pixel image from an input stream into the RAM, then reads every 3x3 window and convolves it with a signed 3x3 kernel.
- Emits 36 results in raster order on a valid/ready output.
- Sits between the pixel source and the result sink in the 2D convolution processor; it is the only driver of the RAM port.

---
 rtl/conv_pkg.sv | 34 +++
 rtl/conv_mac.sv | 26 ++
 rtl/conv_ram_master.sv | 147 ++++++++++++++
 tb/tb_conv_ram_master.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, state encoding and helpers for the 3x3 convolution RAM master.
package conv_pkg;
    localparam int IMG_W   = 8;
    localparam int K       = 3;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 8;
    localparam int COEF_W  = 8;
    localparam int ACC_W   = 21;
    localparam int OUT_DIM = IMG_W - K + 1;
    localparam int PROD_W  = DATA_W + COEF_W + 1;
    localparam int KERN_W  = K * K * COEF_W;
    localparam int TAP_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RD,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    function automatic logic signed [COEF_W-1:0] kernel_tap(
        input logic [KERN_W-1:0] kern,
        input logic [TAP_W-1:0]  k
    );
        return $signed(kern[int'(k)*COEF_W +: COEF_W]);
    endfunction

    // Offset of tap k = 3*i + j from the window's top-left pixel.
    function automatic logic [ADDR_W-1:0] tap_offset(input logic [TAP_W-1:0] k);
        return ADDR_W'((int'(k) / K) * IMG_W + (int'(k) % K));
    endfunction
endpackage

// File: rtl/conv_mac.sv
// Clear/enable accumulator: unsigned pixel times signed weight into a signed sum.
module conv_mac
    import conv_pkg::*;
(
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     en,
    input  logic [DATA_W-1:0]        pix,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [ACC_W-1:0]  sum_next
);
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] prod;

    always_comb begin
        prod     = $signed({1'b0, pix}) * coef;
        sum_next = acc + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
    end

    always_ff @(posedge clk) begin
        if (clr)
            acc <= '0;
        else if (en)
            acc <= sum_next;
    end
endmodule

// File: rtl/conv_ram_master.sv
// Loads an 8x8 image into the single-port RAM, then streams out every 3x3
// convolution result in raster order.
module conv_ram_master
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [KERN_W-1:0]       kernel,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic                    ram_wr,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       ram_din,
    input  logic [DATA_W-1:0]       ram_dout,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_data,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);
    state_t                  state;
    logic [ADDR_W-1:0]       cnt;
    logic [2:0]              row;
    logic [2:0]              col;
    logic [TAP_W-1:0]        k;
    logic [KERN_W-1:0]       kern_q;
    logic                    vld_p0;
    logic                    vld_p1;
    logic [TAP_W-1:0]        k_p0;
    logic [TAP_W-1:0]        k_p1;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    mac_clr;
    logic signed [ACC_W-1:0] sum_next;

    always_comb begin
        rd_addr = ADDR_W'(int'(row) * IMG_W + int'(col)) + tap_offset(k);
        mac_clr = (state == S_RD) && (k == '0);
    end

    conv_mac u_mac (
        .clk      (clk),
        .clr      (mac_clr),
        .en       (vld_p1),
        .pix      (ram_dout),
        .coef     (kernel_tap(kern_q, k_p1)),
        .sum_next (sum_next)
    );

    // Stage p0: address registered onto the RAM port; p1: RAM read data returns.
    always_ff @(posedge clk) begin
        k_p0 <= k;
        k_p1 <= k_p0;
        if (state == S_IDLE && start)
            kern_q <= kernel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            row       <= '0;
            col       <= '0;
            k         <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            in_ready  <= 1'b0;
            ram_wr    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            vld_p1 <= vld_p0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    ram_wr <= in_valid && in_ready;
                    if (in_valid && in_ready) begin
                        ram_addr <= cnt;
                        ram_din  <= in_data;
                        cnt      <= cnt + 1'b1;
                        if (cnt == '1) begin
                            in_ready <= 1'b0;
                            row      <= '0;
                            col      <= '0;
                            k        <= '0;
                            state    <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    ram_wr   <= 1'b0;
                    ram_addr <= rd_addr;
                    vld_p0   <= 1'b1;
                    if (k == TAP_W'(K*K-1))
                        state <= S_DRAIN;
                    else
                        k <= k + 1'b1;
                end
                S_DRAIN: begin
                    // Wait for the last tap's read data to come back through the RAM.
                    if (vld_p1 && k_p1 == TAP_W'(K*K-1)) begin
                        out_data  <= sum_next;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (row == 3'(OUT_DIM-1) && col == 3'(OUT_DIM-1)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            k <= '0;
                            if (col == 3'(OUT_DIM-1)) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                            state <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_ram_master.sv
// Directed bench for conv_ram_master with a behavioural 64x8 single-port RAM.
module tb_conv_ram_master;
    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [71:0]         kernel = '0;
    logic                in_valid = 1'b0;
    logic [7:0]          in_data = '0;
    logic                in_ready;
    logic                ram_wr;
    logic [5:0]          ram_addr;
    logic [7:0]          ram_din;
    logic [7:0]          ram_dout = '0;
    logic                out_valid;
    logic signed [20:0]  out_data;
    logic                out_ready = 1'b0;
    logic                busy;
    logic                done;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [64];
    int          wr_n = 0;
    logic [5:0]  wlog_a [1024];
    logic [7:0]  wlog_d [1024];
    int          done_cnt = 0;

    int                 img [64];
    logic [71:0]        kern_cur;
    logic signed [20:0] res [36];

    conv_ram_master dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .kernel    (kernel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr]        <= ram_din;
            ram_dout             <= 8'h00;
            wlog_a[wr_n % 1024]  <= ram_addr;
            wlog_d[wr_n % 1024]  <= ram_din;
            wr_n                 <= wr_n + 1;
        end else begin
            ram_dout <= mem[ram_addr];
        end
        if (done)
            done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_conv(input int r, input int c);
        longint s = 0;
        logic signed [7:0] w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                w = kern_cur[(3*i+j)*8 +: 8];
                s += longint'(img[(r+i)*8 + c + j]) * longint'(w);
            end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [71:0] kv);
        kernel   = kv;
        kern_cur = kv;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        kernel   = '0;
    endtask

    task automatic load_image(input bit toggle, input bit extra_start);
        int  idx = 0;
        int  cyc = 0;
        bit  ph  = 1'b1;
        bit  hs;
        while (idx < 64 && cyc < 1000) begin
            in_valid = toggle ? ph : 1'b1;
            ph       = !ph;
            in_data  = 8'(img[idx]);
            start    = extra_start && (cyc == 15);
            kernel   = extra_start ? 72'h0 : kernel;
            hs       = in_valid && in_ready;
            tick();
            cyc++;
            if (hs) idx++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("load_count", idx, 64);
    endtask

    task automatic collect(input bit bp);
        for (int n = 0; n < 36; n++) begin
            int w = 0;
            while (!out_valid && w < 200) begin
                tick();
                w++;
            end
            if (!out_valid) begin
                chk("out_valid_timeout", 0, 1);
                return;
            end
            if (bp && n == 0) begin
                logic signed [20:0] d0;
                logic [5:0]         a0;
                d0 = out_data;
                a0 = ram_addr;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    chk("bp_valid", out_valid, 1);
                    chk("bp_data", out_data, d0);
                    chk("bp_addr", ram_addr, a0);
                    chk("bp_wr", ram_wr, 0);
                end
            end
            res[n]    = out_data;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (n < 35) chk("valid_drop", out_valid, 0);
        end
    endtask

    task automatic run_job(input logic [71:0] kv, input bit toggle, input bit bp, input bit extra_start);
        int base  = wr_n;
        int dbase = done_cnt;
        int w     = 0;
        pulse_start(kv);
        chk("busy_after_start", busy, 1);
        chk("in_ready_load", in_ready, 1);
        load_image(toggle, extra_start);
        collect(bp);
        while (busy && w < 50) begin
            tick();
            w++;
        end
        tick();
        chk("busy_idle", busy, 0);
        chk("done_pulses", done_cnt - dbase, 1);
        chk("write_count", wr_n - base, 64);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("wr_addr%0d", i), wlog_a[(base+i) % 1024], i);
            chk($sformatf("wr_data%0d", i), wlog_d[(base+i) % 1024], img[i]);
        end
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_ram_wr", ram_wr, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick();

        // Reset midway through a load
        for (int a = 0; a < 64; a++) img[a] = 200;
        pulse_start({9{8'h01}});
        in_valid = 1'b1;
        in_data  = 8'd200;
        repeat (20) tick();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("mid_rst_ram_wr", ram_wr, 0);
        chk("mid_rst_ram_addr", ram_addr, 0);
        chk("mid_rst_ram_din", ram_din, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 0);
        chk("post_rst_ram_wr", ram_wr, 0);

        // Ramp image, all weights +1
        for (int a = 0; a < 64; a++) img[a] = a;
        run_job({9{8'h01}}, 1'b0, 1'b0, 1'b0);
        chk("ramp_first", res[0], 81);
        chk("ramp_last", res[35], 486);
        for (int n = 0; n < 36; n++)
            chk($sformatf("ramp_res%0d", n), res[n], 9 * (8*(n/6) + (n%6) + 9));

        // Centre-only kernel -1 on a flat 255 image
        for (int a = 0; a < 64; a++) img[a] = 255;
        run_job(72'h00_00_00_00_FF_00_00_00_00, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 36; n++)
            chk($sformatf("centre_res%0d", n), res[n], -255);

        // Backpressure on the first result
        for (int a = 0; a < 64; a++) img[a] = a;
        run_job({9{8'h01}}, 1'b0, 1'b1, 1'b0);
        chk("bp_res0", res[0], 81);
        chk("bp_res1", res[1], 90);

        // Extremes
        for (int a = 0; a < 64; a++) img[a] = 255;
        run_job({9{8'h80}}, 1'b0, 1'b0, 1'b0);
        chk("ext_neg_first", res[0], -293760);
        chk("ext_neg_last", res[35], -293760);
        run_job({9{8'h7F}}, 1'b0, 1'b0, 1'b0);
        chk("ext_pos_first", res[0], 291465);
        chk("ext_pos_last", res[35], 291465);

        // Toggling in_valid plus a stray start while busy
        for (int a = 0; a < 64; a++) img[a] = (a * 37 + 11) % 256;
        run_job(72'h03_FE_01_00_05_FF_80_02_7F, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 36; n++)
            chk($sformatf("mix_res%0d", n), res[n], ref_conv(n/6, n%6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end
endmodule
